// File: rtl/cache_req_arbiter_pkg.sv
// cache_req_arbiter_pkg: op encoding and FSM states shared with the cache controller
package cache_req_arbiter_pkg;
  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_IDLE  = 2'b10
  } op_e;
  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_e;
  function automatic logic is_req(input logic [1:0] op);
    return !op[1];
  endfunction
endpackage

// File: rtl/cache_req_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick; on contention the port not granted last wins
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);
  always_comb gnt_o = &req_i ? {~last_i, last_i} : req_i;
endmodule

// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter: shares one cache CPU port between two requesters with a timeout abort
module cache_req_arbiter
  import cache_req_arbiter_pkg::*;
#(
  parameter int WIDTH_A = 32,
  parameter int WIDTH_D = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req0_op,
  input  logic [1:0]         req1_op,
  input  logic [WIDTH_A-1:0] req0_addr,
  input  logic [WIDTH_A-1:0] req1_addr,
  input  logic [WIDTH_D-1:0] req0_wdata,
  input  logic [WIDTH_D-1:0] req1_wdata,
  output logic               req0_ready,
  output logic               req1_ready,
  output logic               req0_complete,
  output logic               req1_complete,
  output logic               req0_err,
  output logic               req1_err,
  output logic [WIDTH_D-1:0] req0_rdata,
  output logic [WIDTH_D-1:0] req1_rdata,
  output logic [1:0]         cpu_request,
  output logic [WIDTH_A-1:0] cpu_addr,
  output logic [WIDTH_D-1:0] cpu_wdata,
  input  logic [WIDTH_D-1:0] cpu_rdata,
  input  logic               cache_ready,
  input  logic               cache_complete
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
  state_e state_q, state_d;
  logic last_q, sel_q, grant, done, abort;
  logic [1:0] op_q, req_v, gnt, cmp_q, err_q;
  logic [WIDTH_A-1:0] addr_q;
  logic [WIDTH_D-1:0] wdata_q, rd0_q, rd1_q;
  logic [CW-1:0] cnt_q;
  assign req_v = {is_req(req1_op), is_req(req0_op)};
  rr_arb2 u_rr (
    .req_i (req_v),
    .last_i(last_q),
    .gnt_o (gnt)
  );
  always_comb begin
    grant = state_q == S_IDLE && |req_v;
    done = cache_complete && (state_q == S_WAIT || (state_q == S_ISSUE && cache_ready));
    abort = state_q != S_IDLE && !done && cnt_q == CNT_MAX;
    state_d = grant ? S_ISSUE :
              (done || abort) ? S_IDLE :
              (state_q == S_ISSUE && cache_ready) ? S_WAIT : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  // last_q resets to 1 so that port 0 wins the first contention
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      op_q    <= OP_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      cnt_q   <= '0;
      cmp_q   <= '0;
      err_q   <= '0;
    end else begin
      cmp_q <= done ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
      err_q <= abort ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
      if (grant) cnt_q <= '0;
      else if (state_q != S_IDLE && cnt_q != CNT_MAX) cnt_q <= cnt_q + CW'(1);
      if (grant) begin
        sel_q   <= gnt[1];
        last_q  <= gnt[1];
        op_q    <= gnt[1] ? req1_op : req0_op;
        addr_q  <= gnt[1] ? req1_addr : req0_addr;
        wdata_q <= gnt[1] ? req1_wdata : req0_wdata;
      end
      if (done && !sel_q) rd0_q <= cpu_rdata;
      if (done && sel_q) rd1_q <= cpu_rdata;
    end
  end
  assign cpu_request = state_q == S_ISSUE ? op_q : OP_IDLE;
  assign cpu_addr = addr_q;
  assign cpu_wdata = wdata_q;
  assign req0_ready = state_q == S_ISSUE && cache_ready && !sel_q;
  assign req1_ready = state_q == S_ISSUE && cache_ready && sel_q;
  assign {req1_complete, req0_complete} = cmp_q;
  assign {req1_err, req0_err} = err_q;
  assign req0_rdata = rd0_q;
  assign req1_rdata = rd1_q;
endmodule

// File: tb/tb_cache_req_arbiter.sv
// tb_cache_req_arbiter: vector table, directed corner sequences and a randomized transaction-model check
module tb_cache_req_arbiter;
  localparam int TO = 8;
  localparam logic [31:0] C = 32'hCCCCCCCC;
  localparam logic [31:0] A = 32'h00000018;
  localparam logic [31:0] Z = 32'h0;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] req0_op = 2'b10, req1_op = 2'b10;
  logic [31:0] req0_addr = '0, req1_addr = '0, req0_wdata = '0, req1_wdata = '0;
  logic req0_ready, req1_ready, req0_complete, req1_complete, req0_err, req1_err;
  logic [31:0] req0_rdata, req1_rdata, cpu_addr, cpu_wdata;
  logic [31:0] cpu_rdata = '0;
  logic [1:0] cpu_request;
  logic cache_ready = 1'b0, cache_complete = 1'b0;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  cache_req_arbiter #(.WIDTH_A(32), .WIDTH_D(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_addr(req0_addr), .req1_addr(req1_addr),
    .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_complete(req0_complete), .req1_complete(req1_complete),
    .req0_err(req0_err), .req1_err(req1_err),
    .req0_rdata(req0_rdata), .req1_rdata(req1_rdata),
    .cpu_request(cpu_request), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cache_ready(cache_ready), .cache_complete(cache_complete)
  );
  typedef struct {
    logic rst;
    logic [1:0] o0, o1;
    logic cr, cc;
    logic [31:0] rd;
    logic [1:0] e_req, e_rdy, e_cmp, e_err;
    logic [31:0] e_addr, e_rd0, e_rd1;
  } vec_t;
  vec_t tbl[9];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step(input logic r, input logic [1:0] o0, input logic [1:0] o1,
                      input logic c_r, input logic c_c, input logic [31:0] rd,
                      input logic [1:0] e_req, input logic [1:0] e_rdy,
                      input logic [1:0] e_cmp, input logic [1:0] e_err, input string nm);
    @(posedge clk);
    #1;
    rst = r; req0_op = o0; req1_op = o1;
    cache_ready = c_r; cache_complete = c_c; cpu_rdata = rd;
    #3;
    chk({nm, ".req"}, cpu_request, e_req);
    chk({nm, ".rdy"}, {req1_ready, req0_ready}, e_rdy);
    chk({nm, ".cmp"}, {req1_complete, req0_complete}, e_cmp);
    chk({nm, ".err"}, {req1_err, req0_err}, e_err);
  endtask
  // transaction-level reference: one outstanding request, its age and acceptance
  bit m_busy, m_acc;
  logic m_port, m_last;
  logic [1:0] m_op, m_cmp, m_err;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rd[2];
  int m_age;
  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_port = 0; m_last = 1; m_op = 2'b10;
    m_cmp = '0; m_err = '0; m_addr = '0; m_wdata = '0; m_rd[0] = '0; m_rd[1] = '0; m_age = 0;
  endtask
  task automatic model_step();
    bit v0, v1;
    logic p;
    v0 = req0_op < 2;
    v1 = req1_op < 2;
    if (rst) begin
      model_reset();
      return;
    end
    m_cmp = '0;
    m_err = '0;
    if (!m_busy) begin
      if (v0 || v1) begin
        p = (v0 && v1) ? !m_last : v1;
        m_busy = 1; m_acc = 0; m_age = 0; m_port = p; m_last = p;
        m_op = p ? req1_op : req0_op;
        m_addr = p ? req1_addr : req0_addr;
        m_wdata = p ? req1_wdata : req0_wdata;
      end
    end else if (cache_complete && (m_acc || cache_ready)) begin
      m_rd[m_port] = cpu_rdata;
      m_cmp[m_port] = 1'b1;
      m_busy = 0;
    end else if (m_age == TO - 1) begin
      m_err[m_port] = 1'b1;
      m_busy = 0;
    end else begin
      if (cache_ready) m_acc = 1;
      m_age++;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic s;
    logic [1:0] e_rdy;
    tbl[0] = '{1'b0, 2'd0, 2'd2, 1'b0, 1'b0, Z, 2'd2, 2'd0, 2'd0, 2'd0, Z, Z, Z};
    tbl[1] = '{1'b0, 2'd2, 2'd2, 1'b0, 1'b0, Z, 2'd0, 2'd0, 2'd0, 2'd0, A, Z, Z};
    tbl[2] = '{1'b0, 2'd2, 2'd2, 1'b0, 1'b0, Z, 2'd0, 2'd0, 2'd0, 2'd0, A, Z, Z};
    tbl[3] = '{1'b0, 2'd2, 2'd2, 1'b1, 1'b0, Z, 2'd0, 2'd1, 2'd0, 2'd0, A, Z, Z};
    tbl[4] = '{1'b0, 2'd2, 2'd2, 1'b0, 1'b1, C, 2'd2, 2'd0, 2'd0, 2'd0, A, Z, Z};
    tbl[5] = '{1'b0, 2'd2, 2'd2, 1'b0, 1'b0, Z, 2'd2, 2'd0, 2'd1, 2'd0, A, C, Z};
    tbl[6] = '{1'b0, 2'd2, 2'd2, 1'b1, 1'b1, 32'h12345678, 2'd2, 2'd0, 2'd0, 2'd0, A, C, Z};
    tbl[7] = '{1'b0, 2'd2, 2'd2, 1'b0, 1'b0, Z, 2'd2, 2'd0, 2'd0, 2'd0, A, C, Z};
    tbl[8] = '{1'b0, 2'd3, 2'd3, 1'b1, 1'b0, Z, 2'd2, 2'd0, 2'd0, 2'd0, A, C, Z};
    req0_addr = A; req0_wdata = 32'h11112222; req1_addr = 32'h2000; req1_wdata = 32'h33334444;
    repeat (2) @(posedge clk);
    #4;
    chk("reset.req", cpu_request, 2'b10);
    chk("reset.addr", cpu_addr, 0);
    chk("reset.wdata", cpu_wdata, 0);
    chk("reset.flags", {req1_ready, req0_ready, req1_complete, req0_complete, req1_err, req0_err}, 0);
    chk("reset.rdata", {req1_rdata, req0_rdata}, 0);
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].o0, tbl[i].o1, tbl[i].cr, tbl[i].cc, tbl[i].rd,
           tbl[i].e_req, tbl[i].e_rdy, tbl[i].e_cmp, tbl[i].e_err, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.addr", i), cpu_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d.rd0", i), req0_rdata, tbl[i].e_rd0);
      chk($sformatf("vec%0d.rd1", i), req1_rdata, tbl[i].e_rd1);
    end
    for (int i = 0; i < 20; i++)
      step(1'b0, 2'd3, 2'd2, 1'b1, 1'b0, Z, 2'd2, 2'd0, 2'd0, 2'd0, "reserved");
    req0_addr = 32'h10; req0_wdata = 32'hFEEDBEEF;
    req1_addr = 32'h01000010; req1_wdata = 32'hDEADDEED;
    step(1'b1, 2'd2, 2'd2, 1'b0, 1'b0, Z, 2'd2, 2'd0, 2'd0, 2'd0, "rr.rst");
    step(1'b0, 2'd1, 2'd1, 1'b0, 1'b0, Z, 2'd2, 2'd0, 2'd0, 2'd0, "rr.both");
    step(1'b0, 2'd1, 2'd1, 1'b1, 1'b1, 32'hAAAA0000, 2'd1, 2'd1, 2'd0, 2'd0, "rr.p0");
    chk("rr.p0.addr", cpu_addr, 32'h10);
    chk("rr.p0.wdata", cpu_wdata, 32'hFEEDBEEF);
    step(1'b0, 2'd1, 2'd1, 1'b0, 1'b0, Z, 2'd2, 2'd0, 2'd1, 2'd0, "rr.p0done");
    step(1'b0, 2'd1, 2'd1, 1'b1, 1'b1, 32'h0BADF00D, 2'd1, 2'd2, 2'd0, 2'd0, "rr.p1");
    chk("rr.p1.addr", cpu_addr, 32'h01000010);
    chk("rr.p1.wdata", cpu_wdata, 32'hDEADDEED);
    step(1'b0, 2'd1, 2'd1, 1'b0, 1'b0, Z, 2'd2, 2'd0, 2'd2, 2'd0, "rr.p1done");
    step(1'b0, 2'd2, 2'd2, 1'b1, 1'b1, 32'h5555AAAA, 2'd1, 2'd1, 2'd0, 2'd0, "rr.third");
    chk("rr.third.addr", cpu_addr, 32'h10);
    step(1'b0, 2'd2, 2'd2, 1'b0, 1'b0, Z, 2'd2, 2'd0, 2'd1, 2'd0, "rr.thirddone");
    step(1'b0, 2'd2, 2'd2, 1'b0, 1'b0, Z, 2'd2, 2'd0, 2'd0, 2'd0, "rr.idle");
    chk("rr.rd1", req1_rdata, 32'h0BADF00D);
    step(1'b0, 2'd0, 2'd2, 1'b0, 1'b0, Z, 2'd2, 2'd0, 2'd0, 2'd0, "to.grant");
    for (int k = 0; k < 8; k++)
      step(1'b0, 2'd2, 2'd2, k == 1, 1'b0, Z, k < 2 ? 2'd0 : 2'd2, k == 1 ? 2'd1 : 2'd0,
           2'd0, 2'd0, $sformatf("to.k%0d", k));
    step(1'b0, 2'd2, 2'd2, 1'b0, 1'b0, Z, 2'd2, 2'd0, 2'd0, 2'd1, "to.err");
    step(1'b0, 2'd2, 2'd2, 1'b0, 1'b0, Z, 2'd2, 2'd0, 2'd0, 2'd0, "to.after");
    chk("to.rd0", req0_rdata, 32'h5555AAAA);
    req1_addr = 32'h0000ABC0;
    step(1'b0, 2'd2, 2'd0, 1'b0, 1'b0, Z, 2'd2, 2'd0, 2'd0, 2'd0, "rw.grant");
    step(1'b0, 2'd2, 2'd2, 1'b1, 1'b0, Z, 2'd0, 2'd2, 2'd0, 2'd0, "rw.issue");
    step(1'b1, 2'd2, 2'd2, 1'b0, 1'b1, 32'hFFFFFFFF, 2'd2, 2'd0, 2'd0, 2'd0, "rw.rst");
    step(1'b0, 2'd2, 2'd2, 1'b0, 1'b0, Z, 2'd2, 2'd0, 2'd0, 2'd0, "rw.post");
    chk("rw.post.addr", cpu_addr, 0);
    chk("rw.post.wdata", cpu_wdata, 0);
    chk("rw.post.rdata", {req1_rdata, req0_rdata}, 0);
    step(1'b0, 2'd2, 2'd0, 1'b0, 1'b0, Z, 2'd2, 2'd0, 2'd0, 2'd0, "rw.grant2");
    step(1'b0, 2'd2, 2'd2, 1'b1, 1'b1, 32'h13572468, 2'd0, 2'd2, 2'd0, 2'd0, "rw.issue2");
    chk("rw.issue2.addr", cpu_addr, 32'h0000ABC0);
    step(1'b0, 2'd2, 2'd2, 1'b0, 1'b0, Z, 2'd2, 2'd0, 2'd2, 2'd0, "rw.done2");
    chk("rw.rd1", req1_rdata, 32'h13572468);
    chk("rw.rd0", req0_rdata, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    for (int i = 0; i < 600; i++) begin
      rst = $urandom_range(0, 63) == 0;
      req0_op = 2'($urandom_range(0, 3));
      req1_op = 2'($urandom_range(0, 3));
      req0_addr = $urandom; req1_addr = $urandom;
      req0_wdata = $urandom; req1_wdata = $urandom;
      cache_ready = $urandom_range(0, 1) == 1;
      cache_complete = $urandom_range(0, 2) == 0;
      cpu_rdata = $urandom;
      #3;
      s = m_busy && !m_acc && cache_ready;
      e_rdy = {s && m_port, s && !m_port};
      chk($sformatf("rnd%0d.req", i), cpu_request, (m_busy && !m_acc) ? m_op : 2'b10);
      chk($sformatf("rnd%0d.rdy", i), {req1_ready, req0_ready}, e_rdy);
      chk($sformatf("rnd%0d.cmp", i), {req1_complete, req0_complete}, m_cmp);
      chk($sformatf("rnd%0d.err", i), {req1_err, req0_err}, m_err);
      chk($sformatf("rnd%0d.addr", i), cpu_addr, m_addr);
      chk($sformatf("rnd%0d.wdata", i), cpu_wdata, m_wdata);
      chk($sformatf("rnd%0d.rd0", i), req0_rdata, m_rd[0]);
      chk($sformatf("rnd%0d.rd1", i), req1_rdata, m_rd[1]);
      model_step();
      @(posedge clk);
      #1;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_req_arbiter.md
CACHE_REQ_ARBITER -- requirements
Module: cache_req_arbiter

Interface
REQ-001 SHALL have parameters: WIDTH_A, default 32, address width; WIDTH_D, default 32, data width; TIMEOUT, default 1024, max WAIT cycles before abort.
REQ-002 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have req0_op, req1_op  input  2 each  requester op: 00 read, 01 write, 10 idle, 11 reserved (treated as idle).
REQ-005 SHALL have req0_addr, req1_addr  input  WIDTH_A each  requester address; req0_wdata, req1_wdata  input  WIDTH_D each  write data.
REQ-006 SHALL have req0_ready, req1_ready  output  1 each  request accepted by cache.
REQ-007 SHALL have req0_complete, req1_complete  output  1 each  one-cycle done pulse; req0_err, req1_err  output  1 each  one-cycle timeout pulse.
REQ-008 SHALL have req0_rdata, req1_rdata  output  WIDTH_D each  last captured cache read data.
REQ-009 SHALL have cpu_request  output  2, cpu_addr  output  WIDTH_A, cpu_wdata  output  WIDTH_D  shared cache CPU port (same op encoding).
REQ-010 SHALL have cpu_rdata  input  WIDTH_D, cache_ready  input  1, cache_complete  input  1  cache responses.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-012 IDLE: op 00/01 on either port SHALL grant one requester, latch its index, op, addr, wdata, and go to ISSUE next cycle.
REQ-013 Both requesting in same cycle SHALL grant the port not granted last (round-robin); after reset, port 0 wins.
REQ-014 Last-grant pointer SHALL update only on a grant in IDLE.
REQ-015 Grant-to-port latency SHALL be 1 cycle: request seen in IDLE at cycle N -> cpu_request driven at N+1.
REQ-016 ISSUE: cpu_request/cpu_addr/cpu_wdata SHALL hold latched values, stable until cache_ready.
REQ-017 ISSUE with cache_ready=1: reqX_ready of granted port SHALL be 1 that cycle (combinational); next state WAIT.
REQ-018 Outside ISSUE, cpu_request SHALL be 10; cpu_addr/cpu_wdata SHALL hold last latched values.
REQ-019 WAIT (or ISSUE with cache_ready and cache_complete both 1): on cache_complete, SHALL capture cpu_rdata into granted port's rdata register, pulse its complete the next cycle, return to IDLE.
REQ-020 Non-granted port's rdata, ready, complete SHALL be unaffected.
REQ-021 Op/addr changes on a non-granted or already-accepted port SHALL be ignored until next IDLE grant.
REQ-022 Cycle counter SHALL clear on entry to ISSUE and increment each ISSUE/WAIT cycle; reaching TIMEOUT-1 without completion SHALL pulse granted port's err next cycle (no complete, rdata unchanged) and return to IDLE.
REQ-023 Counter width SHALL be $clog2(TIMEOUT); it SHALL never wrap.
REQ-024 cache_ready or cache_complete in IDLE SHALL be ignored.
REQ-025 Back-to-back: a grant SHALL be possible in the IDLE cycle immediately following completion.

Reset
REQ-026 rst=1 at any clock SHALL force IDLE, pointer to favour port 0, counter 0, cpu_request=10, cpu_addr=0, cpu_wdata=0, all ready/complete/err=0, both rdata=0.
REQ-027 Reset mid-transaction SHALL abort silently: no complete or err pulse.

Structure
REQ-028 Op encoding (READ, WRITE, IDLE) and FSM state enum SHALL live in the shared cache package, shared with the cache controller.
REQ-029 Round-robin selection SHALL be a sub-module rr_arb2 (2 requests, last-grant input, one-hot grant output); everything else in one module.

Verification
REQ-030 Port 0 read 0x00000018, cache_ready after 2 cycles, cache_complete with cpu_rdata=0xCCCCCCCC -> cpu_request=00 for ISSUE only, req0_ready once, req0_complete 1 cycle later, req0_rdata=0xCCCCCCCC, req1 outputs 0.
REQ-031 Both ports write at same cycle after reset (port0 0x10/0xFEEDBEEF, port1 0x01000010/0xDEADDEED) -> port 0 served first, port 1 next; third simultaneous request then goes to port 0.
REQ-032 cache_ready and cache_complete both 1 in first ISSUE cycle -> single ready, complete next cycle, IDLE afterwards.
REQ-033 TIMEOUT=8, cache never completes -> req0_err pulses exactly 8 cycles after ISSUE entry, no complete, cpu_request=10 afterwards.
REQ-034 rst asserted in WAIT -> next cycle all outputs at reset values, no complete/err; subsequent port 1 read served normally.
REQ-035 req0_op=11 held 20 cycles -> cpu_request stays 10, no ready.
